clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode and setup controller for the clock/calendar top. It sits between the raw user controls (`display`, `swap_display`, the three `setup_*` buttons) and the seconds/minutes/hours and day/month/year counters. In RUN mode it forwards the 1 Hz tick to the counters. In SET mode it freezes timekeeping and turns button presses, including held-button auto-repeat, into single-cycle increment pulses for the field shown on the current view. It also owns the time/date view selection and the blink enable for the seven-segment drivers.

## Interface

Parameters:
- `HOLD_CYC`, default 25_000_000: cycles a button must stay held before auto-repeat starts.
- `REPEAT_CYC`, default 5_000_000: cycles between auto-repeat pulses.
- `TIMEOUT_S`, default 30: idle `tick_1hz` count in SET before forced return to RUN.
- `DATE_SHOW_S`, default 5: `tick_1hz` count the date view persists in RUN before it reverts to the time view; 0 disables the revert.
- `CNT_W`, default 25: width of the hold/repeat counter; must hold `HOLD_CYC`.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick_1hz` in 1: one-cycle pulse from the prescaler, free-running.
- `display` in 1: setup request. A rising edge enters SET; a falling edge leaves SET.
- `swap_display` in 1: a rising edge toggles the time/date view.
- `setup_second_day` in 1: increments seconds (time view) or day (date view).
- `setup_minute_month` in 1: increments minutes (time view) or month (date view).
- `setup_hour_year` in 1: increments hours (time view) or year (date view).
- `run_tick` out 1: count enable to the seconds counter.
- `inc_sec`, `inc_min`, `inc_hour`, `inc_day`, `inc_month`, `inc_year` out 1 each: single-cycle increment pulses.
- `view_date` out 1: 0 = time view on the LEDs, 1 = date view.
- `setup_mode` out 1: 1 while in SET.
- `blink` out 1: blank enable for the digits of the active view.

All inputs are already synchronised. All outputs are registered.

## Operation

- Mode FSM has two states, RUN and SET. Reset state is RUN.
  - RUN → SET on a `display` rising edge.
  - SET → RUN on a `display` falling edge, or when the idle count reaches `TIMEOUT_S`.
  - After a timeout, the FSM stays in RUN even if `display` is still high. Re-entry requires a new rising edge.
- Edge detection uses a one-cycle-delayed copy of each input. All delayed copies reset to 0.
- RUN behaviour:
  - `run_tick` = `tick_1hz`.
  - All `inc_*` outputs are 0 and button activity is ignored.
  - A `swap_display` edge toggles `view_date`.
  - While `view_date`=1, a counter counts `tick_1hz`. When it reaches `DATE_SHOW_S`, `view_date` is cleared. The counter is cleared on every toggle.
- SET behaviour:
  - `run_tick`=0 and `blink` toggles on each `tick_1hz`.
  - A `swap_display` edge toggles `view_date`. There is no auto-revert in SET.
- Key FSM runs only in SET. States:
  - K_IDLE → K_HOLD on a rising edge of any `setup_*` button. The winning button is latched with priority hour_year > minute_month > second_day. One increment pulse is emitted for the latched field and the counter is cleared.
  - K_HOLD → K_RPT when the counter reaches `HOLD_CYC`-1 while the latched button is still high. This transition emits a pulse and clears the counter.
  - K_RPT emits a pulse every `REPEAT_CYC` cycles.
  - K_HOLD or K_RPT → K_IDLE when the latched button goes low.
  - Other buttons are ignored while one is latched.
- Field mapping: the pulse goes to sec/min/hour when `view_date`=0 and to day/month/year when `view_date`=1. `view_date` is sampled at each pulse, so a swap during a hold retargets the following repeats.
- Idle counter: counts `tick_1hz` in SET and clears on any increment pulse and on SET entry.
- Leaving SET forces the key FSM to K_IDLE. It also sets `blink`=0 and clears the idle counter.
- Saturation: the hold, repeat, idle and date counters saturate at their terminal value and never wrap.

## Timing

- Reset value of every output is 0: `run_tick`, all `inc_*`, `view_date`, `setup_mode`, `blink`.
- An input change sampled at cycle N is reflected on the registered outputs at cycle N+1.
  - `run_tick` is `tick_1hz` delayed by one cycle.
  - A button rising edge sampled at N gives an `inc_*` pulse at N+1 lasting exactly one cycle.
- `setup_mode` rises at N+1 after a `display` rising edge at N. `blink` goes to 1 in the same cycle.
- A button edge arriving in the same cycle as the `display` edge that enters SET is ignored, because the mode is still RUN when it is sampled.
- Auto-repeat: the first repeat pulse comes `HOLD_CYC` cycles after the initial pulse. Later pulses are spaced exactly `REPEAT_CYC` cycles apart.
- `tick_1hz` coincident with a `display` rising edge: that tick is still forwarded as `run_tick`.
- Assertion of `rst` in the middle of any operation returns everything to reset values on the next edge. No pulse is emitted on the reset cycle.

## Structure

- Package `clock_ctrl_pkg`:
  - mode enum (RUN, SET);
  - key state enum (K_IDLE, K_HOLD, K_RPT);
  - button index enum (BTN_SD, BTN_MM, BTN_HY);
  - default constants for the parameters.
- Sub-module `key_repeat` contains the key FSM and the hold/repeat counter. Its inputs are the three button levels and an enable; its outputs are a pulse and the button index. The top level adds the field mapping, the mode FSM, and the view and blink logic.

## Test plan

Parameters for the bench: `HOLD_CYC`=20, `REPEAT_CYC`=5, `TIMEOUT_S`=3, `DATE_SHOW_S`=2.
- Reset, then 3 `tick_1hz` pulses → 3 `run_tick` pulses, each one cycle late. All `inc_*`=0 and `view_date`=0 throughout.
- Raise `display`, then press `setup_minute_month` for 2 cycles → `setup_mode`=1, exactly one `inc_min` pulse, `run_tick` stays 0 under ticks.
- In SET, hold `setup_hour_year` for 40 cycles → `inc_hour` pulses at relative cycles 1, 21, 26, 31, 36 and none after release.
- In SET, toggle `swap_display`, then press `setup_second_day` and `setup_hour_year` in the same cycle → one `inc_year` pulse and no `inc_day`.
- In SET, hold `display` high and send 3 ticks with no press → return to RUN after the 3rd tick with `blink`=0. Keeping `display` high does not re-enter SET.
- In RUN, a `swap_display` edge followed by 2 ticks → `view_date` is 1, then returns to 0 after the 2nd tick.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and default timing constants for the clock mode/setup controller.
package clock_ctrl_pkg;

    typedef enum logic {RUN, SET} mode_e;

    typedef enum logic [1:0] {K_IDLE, K_HOLD, K_RPT} key_state_e;

    typedef enum logic [1:0] {BTN_SD, BTN_MM, BTN_HY} btn_e;

    localparam int HOLD_CYC_DEF    = 25_000_000;
    localparam int REPEAT_CYC_DEF  = 5_000_000;
    localparam int TIMEOUT_S_DEF   = 30;
    localparam int DATE_SHOW_S_DEF = 5;
    localparam int CNT_W_DEF       = 25;

endpackage

// File: rtl/key_repeat.sv
// Setup-button FSM: one pulse per press, then auto-repeat while held.
// pulse_o/btn_o are combinational; the caller registers them (1-cycle press-to-output).
module key_repeat
    import clock_ctrl_pkg::*;
#(
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int REPEAT_CYC = REPEAT_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       btn_sd_i,
    input  logic       btn_mm_i,
    input  logic       btn_hy_i,
    output logic       pulse_o,
    output logic [1:0] btn_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);

    key_state_e       state_q, state_d;
    btn_e             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       btn_q;
    logic [3:0]       btn_lvl;
    logic [2:0]       btn_rise;
    logic             held;

    assign btn_lvl  = {1'b0, btn_hy_i, btn_mm_i, btn_sd_i};
    assign btn_rise = btn_lvl[2:0] & ~btn_q;
    assign held     = btn_lvl[sel_q];
    assign btn_o    = sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= K_IDLE;
            sel_q   <= BTN_SD;
            cnt_q   <= '0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_lvl[2:0];
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        pulse_o = 1'b0;
        if (!en_i) begin
            state_d = K_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                K_IDLE: begin
                    if (|btn_rise) begin
                        pulse_o = 1'b1;
                        cnt_d   = '0;
                        state_d = K_HOLD;
                        if (btn_rise[2])      sel_d = BTN_HY;
                        else if (btn_rise[1]) sel_d = BTN_MM;
                        else                  sel_d = BTN_SD;
                    end
                end
                K_HOLD: begin
                    if (!held) begin
                        state_d = K_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= HOLD_LAST) begin
                        pulse_o = 1'b1;
                        cnt_d   = '0;
                        state_d = K_RPT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                K_RPT: begin
                    if (!held) begin
                        state_d = K_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= RPT_LAST) begin
                        pulse_o = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = K_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN/SET mode controller: forwards the 1 Hz tick, maps button pulses to field increments,
// owns the time/date view and blink; every output is registered, one cycle after its input.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int HOLD_CYC    = HOLD_CYC_DEF,
    parameter int REPEAT_CYC  = REPEAT_CYC_DEF,
    parameter int TIMEOUT_S   = TIMEOUT_S_DEF,
    parameter int DATE_SHOW_S = DATE_SHOW_S_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic display,
    input  logic swap_display,
    input  logic setup_second_day,
    input  logic setup_minute_month,
    input  logic setup_hour_year,
    output logic run_tick,
    output logic inc_sec,
    output logic inc_min,
    output logic inc_hour,
    output logic inc_day,
    output logic inc_month,
    output logic inc_year,
    output logic view_date,
    output logic setup_mode,
    output logic blink
);

    localparam int IDLE_W = $clog2(TIMEOUT_S + 2);
    localparam int DATE_W = $clog2(DATE_SHOW_S + 2);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S);
    localparam logic [DATE_W-1:0] DATE_LAST = DATE_W'(DATE_SHOW_S);

    mode_e             mode_q, mode_d;
    logic              display_q, swap_q;
    logic              run_tick_q, run_tick_d;
    logic [5:0]        inc_q, inc_d;
    logic              view_q, view_d;
    logic              blink_q, blink_d;
    logic [IDLE_W-1:0] idle_q, idle_d, idle_tick;
    logic [DATE_W-1:0] date_q, date_d;
    logic              disp_rise, disp_fall, swap_rise;
    logic              key_en, key_pulse;
    logic [1:0]        key_btn;
    logic [2:0]        fld;

    assign key_en = (mode_q == SET);

    key_repeat #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .CNT_W      (CNT_W)
    ) u_key (
        .clk      (clk),
        .rst      (rst),
        .en_i     (key_en),
        .btn_sd_i (setup_second_day),
        .btn_mm_i (setup_minute_month),
        .btn_hy_i (setup_hour_year),
        .pulse_o  (key_pulse),
        .btn_o    (key_btn)
    );

    assign disp_rise = display & ~display_q;
    assign disp_fall = ~display & display_q;
    assign swap_rise = swap_display & ~swap_q;
    assign idle_tick = (idle_q < IDLE_LAST) ? idle_q + 1'b1 : idle_q;
    assign fld       = 3'b001 << key_btn;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= RUN;
            display_q  <= 1'b0;
            swap_q     <= 1'b0;
            run_tick_q <= 1'b0;
            inc_q      <= '0;
            view_q     <= 1'b0;
            blink_q    <= 1'b0;
            idle_q     <= '0;
            date_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            display_q  <= display;
            swap_q     <= swap_display;
            run_tick_q <= run_tick_d;
            inc_q      <= inc_d;
            view_q     <= view_d;
            blink_q    <= blink_d;
            idle_q     <= idle_d;
            date_q     <= date_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        run_tick_d = 1'b0;
        inc_d      = '0;
        view_d     = view_q;
        blink_d    = blink_q;
        idle_d     = idle_q;
        date_d     = date_q;

        // The date view only auto-reverts in RUN; SET keeps the counter parked at zero.
        if (swap_rise) begin
            view_d = ~view_q;
            date_d = '0;
        end else if (mode_q == SET) begin
            date_d = '0;
        end else if (view_q && (DATE_SHOW_S != 0) && tick_1hz) begin
            if (date_q + 1'b1 >= DATE_LAST) begin
                view_d = 1'b0;
                date_d = '0;
            end else begin
                date_d = date_q + 1'b1;
            end
        end

        if (key_pulse) begin
            inc_d = view_q ? {fld, 3'b000} : {3'b000, fld};
        end

        if (mode_q == RUN) begin
            run_tick_d = tick_1hz;
            idle_d     = '0;
            blink_d    = 1'b0;
            if (disp_rise) begin
                mode_d  = SET;
                blink_d = 1'b1;
            end
        end else begin
            if (tick_1hz) blink_d = ~blink_q;
            if (key_pulse)     idle_d = '0;
            else if (tick_1hz) idle_d = idle_tick;
            if (disp_fall || (!key_pulse && tick_1hz && idle_tick == IDLE_LAST)) begin
                mode_d  = RUN;
                blink_d = 1'b0;
                idle_d  = '0;
            end
        end
    end

    assign run_tick   = run_tick_q;
    assign inc_sec    = inc_q[0];
    assign inc_min    = inc_q[1];
    assign inc_hour   = inc_q[2];
    assign inc_day    = inc_q[3];
    assign inc_month  = inc_q[4];
    assign inc_year   = inc_q[5];
    assign view_date  = view_q;
    assign setup_mode = (mode_q == SET);
    assign blink      = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench: stimulus queues expected output snapshots per cycle, a negedge monitor compares.
module tb_clock_mode_ctrl;

    logic clk = 1'b0;
    logic rst, tick_1hz, display, swap_display;
    logic setup_second_day, setup_minute_month, setup_hour_year;
    logic run_tick, inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year;
    logic view_date, setup_mode, blink;

    always #5 clk = ~clk;

    clock_mode_ctrl #(
        .HOLD_CYC    (20),
        .REPEAT_CYC  (5),
        .TIMEOUT_S   (3),
        .DATE_SHOW_S (2),
        .CNT_W       (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tick_1hz           (tick_1hz),
        .display            (display),
        .swap_display       (swap_display),
        .setup_second_day   (setup_second_day),
        .setup_minute_month (setup_minute_month),
        .setup_hour_year    (setup_hour_year),
        .run_tick           (run_tick),
        .inc_sec            (inc_sec),
        .inc_min            (inc_min),
        .inc_hour           (inc_hour),
        .inc_day            (inc_day),
        .inc_month          (inc_month),
        .inc_year           (inc_year),
        .view_date          (view_date),
        .setup_mode         (setup_mode),
        .blink              (blink)
    );

    // Pulse vector {run_tick, sec, min, hour, day, month, year}; level vector {view_date, setup_mode, blink}.
    localparam logic [6:0] P_NONE = 7'b0000000;
    localparam logic [6:0] P_RUN  = 7'b1000000;
    localparam logic [6:0] P_SEC  = 7'b0100000;
    localparam logic [6:0] P_MIN  = 7'b0010000;
    localparam logic [6:0] P_HOUR = 7'b0001000;
    localparam logic [6:0] P_YEAR = 7'b0000001;
    localparam logic [2:0] L_ALL  = 3'b111;
    localparam logic [2:0] L_MB   = 3'b011;

    typedef struct {
        int         cyc;
        logic [6:0] p;
        logic [2:0] l;
        logic [2:0] m;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [6:0] p, input logic [2:0] l,
                             input logic [2:0] m, input string nm);
        exp_t e;
        e.cyc = c; e.p = p; e.l = l; e.m = m; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] act_p;
    logic [2:0] act_l;
    bit         hit;
    exp_t       e_mon;

    always @(negedge clk) begin
        act_p = {run_tick, inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year};
        act_l = {view_date, setup_mode, blink};
        hit   = 1'b0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_mon = q.pop_front();
            checks++;
            hit = 1'b1;
            if (e_mon.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expected at cycle %0d, not seen until cycle %0d", e_mon.nm, e_mon.cyc, cyc);
            end else if (act_p !== e_mon.p || (act_l & e_mon.m) !== (e_mon.l & e_mon.m)) begin
                errors++;
                $display("FAIL %s @%0d: got pulses=%b levels=%b, expected pulses=%b levels=%b (mask %b)",
                         e_mon.nm, cyc, act_p, act_l, e_mon.p, e_mon.l, e_mon.m);
            end
        end
        if (!hit) begin
            checks++;
            if (act_p !== P_NONE) begin
                errors++;
                $display("FAIL unexpected_pulse @%0d: got pulses=%b, expected %b", cyc, act_p, P_NONE);
            end
        end
    end

    initial begin
        int p0;
        rst = 1'b1; tick_1hz = 1'b0; display = 1'b0; swap_display = 1'b0;
        setup_second_day = 1'b0; setup_minute_month = 1'b0; setup_hour_year = 1'b0;
        step(3);
        expect_at(cyc, P_NONE, 3'b000, L_ALL, "reset_state");
        rst = 1'b0;
        step(1);

        // RUN: ticks forwarded one cycle late
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1'b1;
            expect_at(cyc + 1, P_RUN, 3'b000, L_ALL, "run_tick_fwd");
            step(1); tick_1hz = 1'b0; step(2);
        end

        // SET entry with coincident tick and button edge: tick forwarded, button ignored
        display = 1'b1; tick_1hz = 1'b1; setup_second_day = 1'b1;
        expect_at(cyc + 1, P_RUN, 3'b011, L_ALL, "set_entry");
        step(1); tick_1hz = 1'b0; setup_second_day = 1'b0; step(1);

        setup_minute_month = 1'b1;
        expect_at(cyc + 1, P_MIN, 3'b011, L_ALL, "set_inc_min");
        step(2); setup_minute_month = 1'b0; step(2);

        tick_1hz = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b010, L_ALL, "set_tick_frozen");
        step(1); tick_1hz = 1'b0; step(2);

        // Held hour button: pulses at +1, +21, +26, +31, +36
        setup_hour_year = 1'b1;
        p0 = cyc;
        expect_at(p0 + 1,  P_HOUR, 3'b010, L_ALL, "hold_first");
        expect_at(p0 + 21, P_HOUR, 3'b010, L_ALL, "hold_rpt1");
        expect_at(p0 + 26, P_HOUR, 3'b010, L_ALL, "hold_rpt2");
        expect_at(p0 + 31, P_HOUR, 3'b010, L_ALL, "hold_rpt3");
        expect_at(p0 + 36, P_HOUR, 3'b010, L_ALL, "hold_rpt4");
        step(40); setup_hour_year = 1'b0; step(10);

        // Date view in SET, simultaneous presses resolve to hour_year
        swap_display = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b110, L_ALL, "set_swap");
        step(1); swap_display = 1'b0; step(1);
        setup_second_day = 1'b1; setup_hour_year = 1'b1;
        expect_at(cyc + 1, P_YEAR, 3'b110, L_ALL, "prio_year");
        step(1); setup_second_day = 1'b0; setup_hour_year = 1'b0; step(3);

        // Idle timeout after 3 ticks with display still high
        tick_1hz = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b111, L_ALL, "idle_tick1");
        step(1); tick_1hz = 1'b0; step(1);
        tick_1hz = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b110, L_ALL, "idle_tick2");
        step(1); tick_1hz = 1'b0; step(1);
        tick_1hz = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b100, L_ALL, "timeout_exit");
        step(1); tick_1hz = 1'b0; step(3);
        expect_at(cyc, P_NONE, 3'b000, L_MB, "no_reentry");
        step(1);

        // RUN: date view reverts after 2 ticks
        display = 1'b0; step(1);
        swap_display = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b000, L_ALL, "run_swap_off");
        step(1); swap_display = 1'b0; step(1);
        swap_display = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b100, L_ALL, "run_swap_on");
        step(1); swap_display = 1'b0; step(1);
        tick_1hz = 1'b1;
        expect_at(cyc + 1, P_RUN, 3'b100, L_ALL, "date_hold");
        step(1); tick_1hz = 1'b0; step(1);
        tick_1hz = 1'b1;
        expect_at(cyc + 1, P_RUN, 3'b000, L_ALL, "date_revert");
        step(1); tick_1hz = 1'b0; step(2);

        // Reset lands on the cycle that would emit the first repeat pulse
        display = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b011, L_ALL, "reenter_set");
        step(1);
        setup_second_day = 1'b1;
        expect_at(cyc + 1, P_SEC, 3'b011, L_ALL, "pre_rst_sec");
        step(20);
        rst = 1'b1;
        expect_at(cyc + 1, P_NONE, 3'b000, L_ALL, "rst_mid_hold");
        step(1);
        rst = 1'b0; display = 1'b0; setup_second_day = 1'b0;
        expect_at(cyc + 1, P_NONE, 3'b000, L_ALL, "post_rst");
        step(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left in queue, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
